// File: rtl/fpm_pkg.sv
// Shared types and helpers for the parametrised pipelined floating-point multiplier.
// Operand classes, exception flag layout and the canonical quiet-NaN pattern.
package fpm_pkg;

   typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_e;

   typedef struct packed {
      logic invalid;
      logic overflow;
      logic underflow;
      logic inexact;
   } fp_flags_t;

   localparam int QNAN_MAX_W = 64;

   // Canonical quiet NaN {0, all ones, 1, 0...}, right-aligned in a wide word.
   function automatic logic [QNAN_MAX_W-1:0] qnan(input int exp_w, input int man_w);
      logic [QNAN_MAX_W-1:0] q;
      q = '0;
      for (int i = 0; i < exp_w; i++) q[man_w+i] = 1'b1;
      q[man_w-1] = 1'b1;
      return q;
   endfunction

endpackage

// File: rtl/fpm_round.sv
// Normalise the raw mantissa product and round it to nearest-even.
// A carry out of rounding renormalises by bumping the exponent.
module fpm_round
   import fpm_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic [2*MAN_W+1:0]       product,
   input  logic signed [EXP_W+1:0]  exp_sum,
   output logic [MAN_W-1:0]         frac,
   output logic signed [EXP_W+1:0]  exp,
   output logic                     inexact
);

   localparam int PW = 2*MAN_W + 2;
   localparam int XW = EXP_W + 2;

   logic [PW-2:0]          norm;
   logic signed [XW-1:0]   exp_n;
   logic                   guard;
   logic                   sticky;
   logic                   lsb;
   logic                   round_up;
   logic [MAN_W:0]         rounded;

   // norm holds everything below the hidden bit; a product in [2,4) gives up one exponent step.
   always_comb begin
      norm     = {product[PW-3:0], 1'b0};
      exp_n    = exp_sum;
      if (product[PW-1]) begin
         norm  = product[PW-2:0];
         exp_n = exp_sum + XW'(1);
      end
      guard    = norm[MAN_W];
      sticky   = |norm[MAN_W-1:0];
      lsb      = norm[MAN_W+1];
      round_up = guard & (sticky | lsb);
      rounded  = {1'b0, norm[PW-2 -: MAN_W]} + {{MAN_W{1'b0}}, round_up};
      frac     = rounded[MAN_W-1:0];
      exp      = rounded[MAN_W] ? exp_n + XW'(1) : exp_n;
      inexact  = guard | sticky;
   end

endmodule

// File: rtl/fpm_pipe_param.sv
// Four-stage pipelined IEEE-style multiplier (unpack, multiply, round, pack) with
// valid/ready flow control; every stage advances together whenever the output can move.
module fpm_pipe_param
   import fpm_pkg::*;
#(
   parameter  int EXP_W = 8,
   parameter  int MAN_W = 23,
   localparam int W     = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] c,
   output logic [3:0]   flags
);

   localparam int BIAS = 2**(EXP_W-1) - 1;
   localparam int PW   = 2*MAN_W + 2;
   localparam int XW   = EXP_W + 2;

   localparam logic [EXP_W-1:0]        EXP_ONES  = '1;
   localparam logic signed [XW-1:0]    EXP_OVF   = XW'(2**EXP_W - 1);
   localparam logic signed [XW-1:0]    EXP_ZERO  = '0;
   localparam logic [QNAN_MAX_W-1:0]   QNAN_FULL = qnan(EXP_W, MAN_W);
   localparam logic [W-1:0]            QNAN      = QNAN_FULL[W-1:0];

   function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
      if (e == '0)
         return ZERO;
      if (e == EXP_ONES)
         return (f == '0) ? INF : NAN;
      return NORM;
   endfunction

   logic adv;

   logic                  v1, v2, v3;
   logic                  s1_sa, s1_sb;
   fp_class_e             s1_ca, s1_cb;
   logic [EXP_W-1:0]      s1_ea, s1_eb;
   logic [MAN_W:0]        s1_ma, s1_mb;

   logic                  s2_sign;
   fp_class_e             s2_ca, s2_cb;
   logic [PW-1:0]         s2_prod;
   logic signed [XW-1:0]  s2_exp;

   logic [MAN_W-1:0]      rnd_frac;
   logic signed [XW-1:0]  rnd_exp;
   logic                  rnd_inexact;

   logic                  s3_sign;
   fp_class_e             s3_ca, s3_cb;
   logic [MAN_W-1:0]      s3_frac;
   logic signed [XW-1:0]  s3_exp;
   logic                  s3_inexact;

   logic [W-1:0]          pack_c;
   fp_flags_t             pack_flags;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // Stage valid bits; bubbles travel with the data rather than being squeezed out.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         v3        <= 1'b0;
         out_valid <= 1'b0;
      end else if (adv) begin
         v1        <= in_valid;
         v2        <= v1;
         v3        <= v2;
         out_valid <= v3;
      end
   end

   always_ff @(posedge clk) begin
      if (adv) begin
         s1_sa   <= a[W-1];
         s1_sb   <= b[W-1];
         s1_ca   <= classify(a[W-2 -: EXP_W], a[MAN_W-1:0]);
         s1_cb   <= classify(b[W-2 -: EXP_W], b[MAN_W-1:0]);
         s1_ea   <= a[W-2 -: EXP_W];
         s1_eb   <= b[W-2 -: EXP_W];
         s1_ma   <= {1'b1, a[MAN_W-1:0]};
         s1_mb   <= {1'b1, b[MAN_W-1:0]};

         s2_sign <= s1_sa ^ s1_sb;
         s2_ca   <= s1_ca;
         s2_cb   <= s1_cb;
         s2_prod <= PW'(s1_ma) * PW'(s1_mb);
         s2_exp  <= XW'(s1_ea) + XW'(s1_eb) - XW'(BIAS);

         s3_sign    <= s2_sign;
         s3_ca      <= s2_ca;
         s3_cb      <= s2_cb;
         s3_frac    <= rnd_frac;
         s3_exp     <= rnd_exp;
         s3_inexact <= rnd_inexact;
      end
   end

   fpm_round #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
   ) u_round (
      .product (s2_prod),
      .exp_sum (s2_exp),
      .frac    (rnd_frac),
      .exp     (rnd_exp),
      .inexact (rnd_inexact)
   );

   // Special operands override the arithmetic path; range checks only apply to normal*normal.
   always_comb begin
      pack_c     = '0;
      pack_flags = '0;
      if (s3_ca == NAN || s3_cb == NAN ||
          (s3_ca == INF && s3_cb == ZERO) || (s3_ca == ZERO && s3_cb == INF)) begin
         pack_c             = QNAN;
         pack_flags.invalid = 1'b1;
      end else if (s3_ca == INF || s3_cb == INF) begin
         pack_c = {s3_sign, EXP_ONES, {MAN_W{1'b0}}};
      end else if (s3_ca == ZERO || s3_cb == ZERO) begin
         pack_c = {s3_sign, {(W-1){1'b0}}};
      end else if (s3_exp >= EXP_OVF) begin
         pack_c              = {s3_sign, EXP_ONES, {MAN_W{1'b0}}};
         pack_flags.overflow = 1'b1;
         pack_flags.inexact  = 1'b1;
      end else if (s3_exp <= EXP_ZERO) begin
         pack_c               = {s3_sign, {(W-1){1'b0}}};
         pack_flags.underflow = 1'b1;
         pack_flags.inexact   = 1'b1;
      end else begin
         pack_c             = {s3_sign, s3_exp[EXP_W-1:0], s3_frac};
         pack_flags.inexact = s3_inexact;
      end
   end

   // Result and flags only change when a live op lands; otherwise they keep their last value.
   always_ff @(posedge clk) begin
      if (rst) begin
         c     <= '0;
         flags <= '0;
      end else if (adv && v3) begin
         c     <= pack_c;
         flags <= pack_flags;
      end
   end

endmodule

// File: tb/tb_fpm_pipe_param.sv
// Scoreboard bench for fpm_pipe_param: single and half precision instances, directed
// corner cases plus randomized streams with backpressure, checked against an arithmetic model.
module tb_fpm_pipe_param;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic [3:0]  f;
      int          cyc;
      bit          lat;
   } op_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] a, b, c;
   logic [3:0]  flags;
   logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
   logic [15:0] h_a, h_b, h_c;
   logic [3:0]  h_flags;

   int  checks = 0;
   int  passed = 0;
   int  cyc    = 0;
   op_t pend[$];
   op_t sbq[$];
   op_t hq[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fpm_pipe_param dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .c(c), .flags(flags)
   );

   fpm_pipe_param #(.EXP_W(5), .MAN_W(10)) dut_h (
      .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready), .a(h_a), .b(h_b),
      .out_valid(h_out_valid), .out_ready(h_out_ready), .c(h_c), .flags(h_flags)
   );

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passed++;
      else $display("[TB] FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
   endtask

   task automatic fail_now(input string name, input logic [31:0] act);
      checks++;
      $display("[TB] FAIL %s: got %h with nothing expected (t=%0t)", name, act, $time);
   endtask

   // Reference multiply from the format rules: integer mantissa product, remainder-based RNE.
   function automatic logic [35:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                           input int ew, input int mw);
      longint emax, bias, ex, ey, fx, fy, p, q, rem, half, e, sgn, zero_w, inf_w, qnan_w;
      int     shift;
      bit     xn, yn, xi, yi, xz, yz, inx;
      emax   = (64'd1 << ew) - 1;
      bias   = (64'd1 << (ew - 1)) - 1;
      ex     = (x >> mw) & emax;
      ey     = (y >> mw) & emax;
      fx     = x & ((64'd1 << mw) - 1);
      fy     = y & ((64'd1 << mw) - 1);
      sgn    = ((x >> (ew + mw)) ^ (y >> (ew + mw))) & 1;
      xn     = (ex == emax) && (fx != 0);
      yn     = (ey == emax) && (fy != 0);
      xi     = (ex == emax) && (fx == 0);
      yi     = (ey == emax) && (fy == 0);
      xz     = (ex == 0);
      yz     = (ey == 0);
      zero_w = sgn << (ew + mw);
      inf_w  = zero_w | (emax << mw);
      qnan_w = (emax << mw) | (64'd1 << (mw - 1));
      if (xn || yn || (xi && yz) || (yi && xz)) return {4'b1000, 32'(qnan_w)};
      if (xi || yi) return {4'b0000, 32'(inf_w)};
      if (xz || yz) return {4'b0000, 32'(zero_w)};
      p     = ((64'd1 << mw) | fx) * ((64'd1 << mw) | fy);
      e     = ex + ey - bias;
      shift = mw;
      if (p >= (64'd1 << (2*mw + 1))) begin
         shift = mw + 1;
         e     = e + 1;
      end
      q    = p >> shift;
      rem  = p & ((64'd1 << shift) - 1);
      half = 64'd1 << (shift - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'd1 << (mw + 1))) begin
         q = q >> 1;
         e = e + 1;
      end
      inx = (rem != 0);
      if (e >= emax) return {4'b0101, 32'(inf_w)};
      if (e <= 0) return {4'b0011, 32'(zero_w)};
      return {3'b000, inx, 32'(zero_w | (e << mw) | (q & ((64'd1 << mw) - 1)))};
   endfunction

   function automatic logic [31:0] rand_op(input int ew, input int mw);
      logic [31:0] x;
      int          bias, e;
      x = $urandom;
      if (ew + mw < 31) x = x & ((32'd1 << (ew + mw + 1)) - 1);
      bias = (1 << (ew - 1)) - 1;
      if ($urandom_range(0, 3) != 0) begin
         e = bias - bias/4 + int'($urandom_range(0, bias/2));
         x = (x & ~(((32'd1 << ew) - 1) << mw)) | (32'(e) << mw);
      end
      return x;
   endfunction

   function automatic op_t make_op(input logic [31:0] x, input logic [31:0] y, input int ew,
                                   input int mw);
      op_t         o;
      logic [35:0] r;
      r     = ref_mul(x, y, ew, mw);
      o.a   = x;
      o.b   = y;
      o.c   = r[31:0];
      o.f   = r[35:32];
      o.cyc = 0;
      o.lat = 1'b0;
      return o;
   endfunction

   function automatic op_t fixed_op(input logic [31:0] x, input logic [31:0] y,
                                    input logic [31:0] z, input logic [3:0] f);
      op_t o;
      o.a = x; o.b = y; o.c = z; o.f = f; o.cyc = 0; o.lat = 1'b0;
      return o;
   endfunction

   // Monitor for the single-precision instance: every visible result is compared to the queue head.
   always @(negedge clk) begin
      op_t e;
      if (!rst) begin
         check_output("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
         if (out_valid) begin
            if (sbq.size() == 0) begin
               fail_now("unexpected_result", c);
            end else begin
               check_output("c", c, sbq[0].c);
               check_output("flags", 32'(flags), 32'(sbq[0].f));
               if (out_ready) begin
                  e = sbq.pop_front();
                  if (e.lat) check_output("latency", 32'(cyc - e.cyc), 32'd4);
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      op_t e;
      if (!rst && h_out_valid) begin
         if (hq.size() == 0) begin
            fail_now("h_unexpected_result", 32'(h_c));
         end else begin
            e = hq.pop_front();
            check_output("h_c", 32'(h_c), e.c);
            check_output("h_flags", 32'(h_flags), 32'(e.f));
         end
      end
   end

   // Mode 0: always ready; mode 1: three-cycle stall mid-stream; mode 2: random gaps and stalls.
   task automatic apply_stimulus(input int mode);
      bit busy = 1'b0;
      int t    = 0;
      op_t e;
      while ((pend.size() > 0 || sbq.size() > 0 || busy) && t < 600) begin
         @(posedge clk);
         #1;
         case (mode)
            1:       out_ready = !(t >= 5 && t < 8);
            2:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b1;
         endcase
         if (!busy) begin
            if (pend.size() > 0 && (mode != 2 || $urandom_range(0, 3) != 0)) begin
               busy     = 1'b1;
               in_valid = 1'b1;
               a        = pend[0].a;
               b        = pend[0].b;
            end else begin
               in_valid = 1'b0;
            end
         end
         @(negedge clk);
         if (busy && in_ready) begin
            e     = pend.pop_front();
            e.cyc = cyc;
            e.lat = (mode == 0);
            sbq.push_back(e);
            busy  = 1'b0;
         end
         t++;
      end
      if (t >= 600) fail_now("stream_timeout", 32'(sbq.size() + pend.size()));
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      op_t e;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      h_in_valid = 1'b0; h_out_ready = 1'b1; h_a = '0; h_b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_output("rst_out_valid", 32'(out_valid), 32'd0);
      check_output("rst_c", c, 32'd0);
      check_output("rst_flags", 32'(flags), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      $display("[TB] directed single-precision cases");
      pend.push_back(fixed_op(32'h40000000, 32'h40800000, 32'h41000000, 4'b0000));
      pend.push_back(fixed_op(32'h42FA4000, 32'h41410000, 32'h44BCAA40, 4'b0000));
      pend.push_back(fixed_op(32'h7F800000, 32'h73800000, 32'h7F800000, 4'b0000));
      pend.push_back(fixed_op(32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000));
      pend.push_back(fixed_op(32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000));
      pend.push_back(fixed_op(32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101));
      pend.push_back(fixed_op(32'h00800000, 32'h00800000, 32'h00000000, 4'b0011));
      pend.push_back(fixed_op(32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001));
      pend.push_back(fixed_op(32'hFF800000, 32'h7FC00001, 32'h7FC00000, 4'b1000));
      apply_stimulus(0);

      $display("[TB] eight back-to-back ops with a stall");
      for (int i = 0; i < 8; i++) pend.push_back(make_op(rand_op(8, 23), rand_op(8, 23), 8, 23));
      apply_stimulus(1);

      $display("[TB] randomized stream with random backpressure");
      for (int i = 0; i < 60; i++) pend.push_back(make_op(rand_op(8, 23), rand_op(8, 23), 8, 23));
      apply_stimulus(2);

      $display("[TB] reset with ops in flight");
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         in_valid = 1'b1; a = rand_op(8, 23); b = rand_op(8, 23); out_ready = 1'b1;
         @(negedge clk);
         if (in_ready) begin
            e = make_op(a, b, 8, 23);
            sbq.push_back(e);
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rst      = 1'b1;
      sbq.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_output("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check_output("mid_rst_c", c, 32'd0);
      repeat (8) @(posedge clk);

      $display("[TB] half-precision instance");
      hq.push_back(fixed_op(32'h4000, 32'h4400, 32'h4800, 4'b0000));
      hq.push_back(fixed_op(32'h7BFF, 32'h7BFF, 32'h7C00, 4'b0101));
      for (int i = 0; i < 20; i++) pend.push_back(make_op(rand_op(5, 10), rand_op(5, 10), 5, 10));
      while (hq.size() > 0) pend.push_front(hq.pop_back());
      while (pend.size() > 0) begin
         @(posedge clk);
         #1;
         h_in_valid = 1'b1;
         h_a        = pend[0].a[15:0];
         h_b        = pend[0].b[15:0];
         @(negedge clk);
         if (h_in_ready) hq.push_back(pend.pop_front());
         else fail_now("h_in_ready", 32'(h_in_ready));
      end
      @(posedge clk);
      #1 h_in_valid = 1'b0;
      for (int i = 0; i < 20 && hq.size() > 0; i++) @(posedge clk);
      if (hq.size() > 0) fail_now("h_drain_timeout", 32'(hq.size()));
      repeat (2) @(posedge clk);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
